// File: rtl/line_mem_responder.sv
// Line-wide memory responder for the cache line bus: fixed-latency load/store service.
// Define LINE_MEM_WRITE_INVALIDATE_EN to broadcast an invalidate pulse after each committed store.
module line_mem_responder #(
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned OFFSET_LENGTH    = 4,
  parameter int unsigned MEM_INDEX_LENGTH = 8,
  parameter int unsigned LATENCY          = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       command_valid,
  input  logic                                       command_store,
  input  logic                                       command_rready,
  input  logic [ADDR_WIDTH-1:0]                      command_addr,
  input  logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]   data_to_bus,
  output logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]   data_from_bus,
  output logic                                       bus_valid,
  output logic                                       bus_ready,
  output logic                                       invalidate,
  output logic [ADDR_WIDTH-1:0]                      invalidate_addr
);

  localparam int unsigned LINE_W = DATA_WIDTH * (2 ** OFFSET_LENGTH);
  localparam int unsigned DEPTH  = 2 ** MEM_INDEX_LENGTH;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ACK} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_next;
  logic                        accept;
  logic                        commit;
  logic                        enter_resp;
  logic                        cap_store;
  logic [MEM_INDEX_LENGTH-1:0] cap_idx;
  logic [LINE_W-1:0]           cap_data;
  logic [MEM_INDEX_LENGTH-1:0] cmd_idx;
  logic [MEM_INDEX_LENGTH-1:0] rd_idx;
  logic [LINE_W-1:0]           mem [DEPTH];
  logic                        unused_addr_bits;

  // Upper address bits alias onto the same line by design.
  assign cmd_idx          = command_addr[OFFSET_LENGTH+MEM_INDEX_LENGTH-1:OFFSET_LENGTH];
  assign unused_addr_bits = ^command_addr;
  assign rd_idx           = (state == IDLE) ? cmd_idx : cap_idx;
  assign bus_valid        = (state == RESP) && command_rready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (command_valid) begin
          accept   = 1'b1;
          cnt_next = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) state_next = command_store ? ACK : RESP;
          else              state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = cap_store ? ACK : RESP;
      end
      RESP: begin
        if (command_rready) state_next = IDLE;
      end
      ACK: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    enter_resp = (state_next == RESP) && (state != RESP);
  end

  // Command fields are only meaningful after acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_store <= command_store;
      cap_idx   <= cmd_idx;
      cap_data  <= data_to_bus;
    end
  end

  // Backing store: written as the ACK cycle closes, before any later acceptance.
  always_ff @(posedge clk) begin
    if (commit) mem[cap_idx] <= cap_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_from_bus <= '0;
      bus_ready     <= 1'b0;
    end else begin
      bus_ready <= (state_next == ACK);
      if (enter_resp) data_from_bus <= mem[rd_idx];
    end
  end

`ifdef LINE_MEM_WRITE_INVALIDATE_EN
  logic [ADDR_WIDTH-1:0] cap_addr;

  always_ff @(posedge clk) begin
    if (accept) cap_addr <= {command_addr[ADDR_WIDTH-1:OFFSET_LENGTH], {OFFSET_LENGTH{1'b0}}};
  end

  // One-cycle pulse in the cycle after the store commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invalidate      <= 1'b0;
      invalidate_addr <= '0;
    end else begin
      invalidate <= commit;
      if (commit) invalidate_addr <= cap_addr;
    end
  end
`else
  assign invalidate      = 1'b0;
  assign invalidate_addr = '0;
`endif

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Memory-side responder for the cache line bus driven by the direct-mapped caches. It accepts one line command at a time (load or store), serves it from an internal line-wide backing store after a fixed latency, and returns data with `bus_valid` or acknowledges with `bus_ready`. Completed stores broadcast a one-cycle `invalidate` so other caches drop stale copies.

## Interface
- `ADDR_WIDTH`, 64, command address width.
- `DATA_WIDTH`, 64, word width.
- `OFFSET_LENGTH`, 4, log2 words per line; line = `DATA_WIDTH*2**OFFSET_LENGTH` bits.
- `MEM_INDEX_LENGTH`, 8, log2 lines in the backing store.
- `LATENCY`, 4, cycles from acceptance to response; legal range 1..255.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `command_valid`  in  1  request present; held by the cache until completion.
- `command_store`  in  1  1 = store line, 0 = load line.
- `command_rready`  in  1  cache can take load data this cycle.
- `command_addr`  in  ADDR_WIDTH  line address; low OFFSET_LENGTH bits ignored.
- `data_to_bus`  in  line  store data.
- `data_from_bus`  out  line  load data; valid only while `bus_valid`.
- `bus_valid`  out  1  load data transfer this cycle.
- `bus_ready`  out  1  store accepted and committed this cycle.
- `invalidate`  out  1  one-cycle pulse after each committed store.
- `invalidate_addr`  out  ADDR_WIDTH  line-aligned address of that store.

## Operation
- Line index = `command_addr[OFFSET_LENGTH+MEM_INDEX_LENGTH-1:OFFSET_LENGTH]`; higher bits ignored (aliasing by design).
- Backing store contents are not reset; undefined until written.
- States: IDLE, WAIT, RESP (load), ACK (store).
- IDLE: if `command_valid`, capture store flag, line index, aligned address and `data_to_bus`, load counter with LATENCY-1, go WAIT (or directly RESP/ACK when LATENCY=1).
- WAIT: decrement; at 0 go RESP if load, ACK if store. Command inputs ignored while not IDLE.
- RESP: `data_from_bus` = stored line; `bus_valid` = `command_rready`. Transfer when `bus_valid`; then go IDLE. Without `command_rready`, stay in RESP, holding data.
- ACK: `bus_ready`=1 for exactly one cycle; captured data written to captured index at the closing edge; go IDLE.
- Every committed store latches its aligned address into `invalidate_addr` and asserts `invalidate` for the following cycle.
- Load after store to the same line returns the new data (write commits before next acceptance).

## Timing
- Reset values: `bus_valid`=0, `bus_ready`=0, `invalidate`=0, `invalidate_addr`=0, `data_from_bus`=0, state IDLE, counter 0.
- Acceptance at edge E0 (IDLE, `command_valid`=1); response cycle is LATENCY cycles after E0.
- Back-to-back: after a RESP/ACK cycle, responder is IDLE the next cycle and may accept a new command that cycle; minimum command-to-command spacing LATENCY+1 cycles.
- `bus_valid` and `bus_ready` never asserted together; each at most one cycle per command.
- `invalidate` may coincide with acceptance of the next command.
- Reset mid-operation: return to IDLE immediately, outputs to reset values; an uncommitted store is dropped; pending `invalidate` cancelled.
- `command_valid` deasserted by the cache mid-service: ignored; service completes.

## Configuration
- `LINE_MEM_WRITE_INVALIDATE_EN` defined: invalidate broadcast as above.
- Not defined: `invalidate` and `invalidate_addr` tied to 0; invalidate address register removed; all else identical.

## Test plan
- Reset, store line 0xA5 repeated to addr 0x1230, LATENCY=4 -> `bus_ready` exactly 4 cycles after acceptance for one cycle; next cycle `invalidate`=1, `invalidate_addr`=0x1230 (macro on), 0 (macro off).
- Load 0x1230 with `command_rready`=1 -> `bus_valid` one cycle at LATENCY, `data_from_bus`=0xA5 pattern.
- Load with `command_rready` held 0 for 3 extra cycles -> `bus_valid`=0, data held; transfer on first cycle rready=1.
- Store 0x1230 then immediately load 0x1238 (same line) -> load returns stored data; command spacing = LATENCY+1.
- Assert `reset` during WAIT of a store to 0x4000 -> outputs 0 immediately, no `bus_ready`, no `invalidate`; later load of 0x4000 returns prior contents.
- LATENCY=1 parameterization: store then load -> responses one cycle after each acceptance.
